// File: rtl/int_res_mem_sequencer_pkg.sv
// int_res_mem_sequencer_pkg: shared types and default geometry for the intermediate-result SRAM sequencer
package int_res_mem_sequencer_pkg;
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_BANK_SIZE = 14336;
  localparam int DEF_N_WORD = 15;
  localparam int BANK_IDX_W = $clog2(DEF_NUM_BANKS);
  typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} DataWidth_t;
  typedef enum logic [1:0] {IDLE, ACC_A, ACC_B, RESP_WAIT} IntResSeqState_t;
  typedef logic [BANK_IDX_W-1:0] bank_idx_t;
endpackage

// File: rtl/int_res_mem_sequencer_if.sv
// int_res_mem_sequencer_if: request/response handshake plus the packed N-bank SRAM port
interface int_res_mem_sequencer_if
  import int_res_mem_sequencer_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int N_WORD = DEF_N_WORD,
  parameter int ADDR_W = $clog2(DEF_NUM_BANKS * DEF_BANK_SIZE),
  parameter int BANK_ADDR_W = $clog2(DEF_BANK_SIZE)
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  DataWidth_t req_width;
  logic [ADDR_W-1:0] req_addr;
  logic [2*N_WORD-1:0] req_wdata;
  logic rsp_valid;
  logic [2*N_WORD-1:0] rsp_rdata;
  logic rsp_err;
  logic [NUM_BANKS-1:0] bank_en;
  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS*BANK_ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS*N_WORD-1:0] bank_wdata;
  logic [NUM_BANKS*N_WORD-1:0] bank_rdata;
  modport master (
    output req_valid, req_write, req_width, req_addr, req_wdata, bank_rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, bank_en, bank_we, bank_addr, bank_wdata
  );
  modport slave (
    input req_valid, req_write, req_width, req_addr, req_wdata, bank_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bank_en, bank_we, bank_addr, bank_wdata
  );
endinterface

// File: rtl/int_res_bank_decoder.sv
// int_res_bank_decoder: flat address to {in_range, bank, local_addr} via a comparator chain
module int_res_bank_decoder #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_SIZE = 14336,
  parameter int IN_W = 17,
  parameter int BANK_W = 2,
  parameter int BANK_ADDR_W = 14
) (
  input logic [IN_W-1:0] addr,
  output logic in_range,
  output logic [BANK_W-1:0] bank,
  output logic [BANK_ADDR_W-1:0] local_addr
);
  always_comb begin
    in_range = addr < IN_W'(NUM_BANKS * BANK_SIZE);
    bank = '0;
    local_addr = addr[BANK_ADDR_W-1:0];
    for (int i = 1; i < NUM_BANKS; i++)
      if (addr >= IN_W'(i * BANK_SIZE)) begin
        bank = BANK_W'(i);
        local_addr = BANK_ADDR_W'(addr - IN_W'(i * BANK_SIZE));
      end
  end
endmodule

// File: rtl/int_res_mem_sequencer.sv
// int_res_mem_sequencer: single/double-width access sequencer for the N-bank intermediate-result SRAM
module int_res_mem_sequencer
  import int_res_mem_sequencer_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int BANK_SIZE = DEF_BANK_SIZE,
  parameter int N_WORD = DEF_N_WORD,
  parameter int TOTAL_WORDS = NUM_BANKS * BANK_SIZE,
  parameter int ADDR_W = $clog2(TOTAL_WORDS),
  parameter int BANK_ADDR_W = $clog2(BANK_SIZE)
) (
  input logic clk,
  input logic rst,
  int_res_mem_sequencer_if.slave bus
);
  localparam int BANK_W = $bits(bank_idx_t);
  IntResSeqState_t state;
  logic [ADDR_W:0] hi_ext, lo_ext;
  logic hi_ok, lo_ok, dbl_in, same_in, err_in, hs;
  bank_idx_t hi_bank, lo_bank, b_hi, b_lo;
  logic [BANK_ADDR_W-1:0] hi_local, lo_local, a_lo;
  logic wr, dbl, same, rd_live;
  logic [N_WORD-1:0] wd_lo, hi_q, w_hi, w_lo;
  logic [2*N_WORD-1:0] rdata_q, live;
  // one extra address bit so addr+1 at the top of the map cannot wrap back into range
  assign hi_ext = {1'b0, bus.req_addr};
  assign lo_ext = hi_ext + (ADDR_W + 1)'(1);
  int_res_bank_decoder #(
    .NUM_BANKS(NUM_BANKS), .BANK_SIZE(BANK_SIZE), .IN_W(ADDR_W + 1),
    .BANK_W(BANK_W), .BANK_ADDR_W(BANK_ADDR_W)
  ) u_dec_hi (.addr(hi_ext), .in_range(hi_ok), .bank(hi_bank), .local_addr(hi_local));
  int_res_bank_decoder #(
    .NUM_BANKS(NUM_BANKS), .BANK_SIZE(BANK_SIZE), .IN_W(ADDR_W + 1),
    .BANK_W(BANK_W), .BANK_ADDR_W(BANK_ADDR_W)
  ) u_dec_lo (.addr(lo_ext), .in_range(lo_ok), .bank(lo_bank), .local_addr(lo_local));
  assign dbl_in = bus.req_width == DOUBLE_WIDTH;
  assign same_in = hi_bank == lo_bank;
  assign err_in = !hi_ok || (dbl_in && !lo_ok);
  assign bus.req_ready = state == IDLE;
  assign hs = bus.req_valid && bus.req_ready;
  assign w_hi = bus.bank_rdata[b_hi*N_WORD +: N_WORD];
  assign w_lo = bus.bank_rdata[b_lo*N_WORD +: N_WORD];
  assign live = dbl ? {same ? hi_q : w_hi, w_lo} : {{N_WORD{w_hi[N_WORD-1]}}, w_hi};
  // SRAM data lands in the response cycle itself, so read data passes through a flop-selected mux and is held afterwards
  assign bus.rsp_rdata = rd_live ? live : rdata_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.bank_en <= '0;
      bus.bank_we <= '0;
      bus.bank_addr <= '0;
      bus.bank_wdata <= '0;
      rd_live <= 1'b0;
      rdata_q <= '0;
      wr <= 1'b0;
      dbl <= 1'b0;
      same <= 1'b0;
      b_hi <= '0;
      b_lo <= '0;
      a_lo <= '0;
      wd_lo <= '0;
      hi_q <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.bank_en <= '0;
      bus.bank_we <= '0;
      rd_live <= 1'b0;
      if (rd_live) rdata_q <= live;
      case (state)
        IDLE: if (hs) begin
          wr <= bus.req_write;
          dbl <= dbl_in;
          same <= same_in;
          b_hi <= hi_bank;
          b_lo <= lo_bank;
          a_lo <= lo_local;
          wd_lo <= bus.req_wdata[N_WORD-1:0];
          if (err_in) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b1;
            rdata_q <= '0;
          end else begin
            state <= ACC_A;
            bus.bank_en[hi_bank] <= 1'b1;
            bus.bank_we[hi_bank] <= bus.req_write;
            bus.bank_addr[hi_bank*BANK_ADDR_W +: BANK_ADDR_W] <= hi_local;
            bus.bank_wdata[hi_bank*N_WORD +: N_WORD] <= dbl_in ? bus.req_wdata[2*N_WORD-1:N_WORD] : bus.req_wdata[N_WORD-1:0];
            if (dbl_in && !same_in) begin
              bus.bank_en[lo_bank] <= 1'b1;
              bus.bank_we[lo_bank] <= bus.req_write;
              bus.bank_addr[lo_bank*BANK_ADDR_W +: BANK_ADDR_W] <= lo_local;
              bus.bank_wdata[lo_bank*N_WORD +: N_WORD] <= bus.req_wdata[N_WORD-1:0];
            end
          end
        end
        ACC_A: if (dbl && same) begin
          state <= ACC_B;
          bus.bank_en[b_lo] <= 1'b1;
          bus.bank_we[b_lo] <= wr;
          bus.bank_addr[b_lo*BANK_ADDR_W +: BANK_ADDR_W] <= a_lo;
          bus.bank_wdata[b_lo*N_WORD +: N_WORD] <= wd_lo;
        end else begin
          state <= IDLE;
          bus.rsp_valid <= 1'b1;
          rd_live <= !wr;
        end
        ACC_B: begin
          hi_q <= w_hi;
          state <= IDLE;
          bus.rsp_valid <= 1'b1;
          rd_live <= !wr;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
